// File: rtl/matrix_mult_seq.sv
// matrix_mult_seq: sequential fixed-point matrix multiplier, C = A*B.
// Operands are latched on an in_vld/in_rdy handshake, one inner-dimension
// index is accumulated per cycle on an MxN MAC array, and the rounded,
// rescaled result is held on C until out_rdy is seen.
// Optional feature: define MATRIX_MULT_SAT_EN to saturate the result to
// DATA_WIDTH bits; when undefined the result wraps (two's complement).
module matrix_mult_seq #(
   parameter int DATA_WIDTH = 16,
   parameter int FORMAT     = 8,
   parameter int M          = 4,
   parameter int K          = 4,
   parameter int N          = 4
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        in_vld,
   output logic                                        in_rdy,
   input  logic signed [M-1:0][K-1:0][DATA_WIDTH-1:0]  A,
   input  logic signed [K-1:0][N-1:0][DATA_WIDTH-1:0]  B,
   output logic signed [M-1:0][N-1:0][DATA_WIDTH-1:0]  C,
   output logic                                        out_vld,
   input  logic                                        out_rdy
);

   // Accumulator wide enough that K full-scale products can never overflow.
   localparam int ACC_W  = 2*DATA_WIDTH + $clog2(K) + 1;
   localparam int KW     = (K > 1) ? $clog2(K) : 1;
   localparam int RND_SH = (FORMAT > 0) ? FORMAT - 1 : 0;
   localparam logic [KW-1:0] K_LAST = KW'(K - 1);
   // Half an output LSB, added before the arithmetic shift (round half up).
   localparam logic signed [ACC_W:0] RND =
      (FORMAT > 0) ? ({{ACC_W{1'b0}}, 1'b1} << RND_SH) : {(ACC_W+1){1'b0}};

   if (FORMAT < 0 || FORMAT > 2*DATA_WIDTH - 1) begin : g_bad_format
      $error("matrix_mult_seq: FORMAT must lie in 0..2*DATA_WIDTH-1");
   end
   if (M < 1 || K < 1 || N < 1) begin : g_bad_dims
      $error("matrix_mult_seq: M, K and N must all be at least 1");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   state_t                                       state_q, state_d;
   logic [KW-1:0]                                k_q, k_d;
   logic                                         rdy_q;
   logic                                         vld_q;
   logic signed [M-1:0][K-1:0][DATA_WIDTH-1:0]   a_q;
   logic signed [K-1:0][N-1:0][DATA_WIDTH-1:0]   b_q;
   logic signed [M-1:0][N-1:0][DATA_WIDTH-1:0]   c_q, c_d;
   logic signed [ACC_W-1:0]                      acc_q [M][N];
   logic signed [ACC_W-1:0]                      sum_d [M][N];
   logic signed [2*DATA_WIDTH-1:0]               prod_s [M][N];
   logic                                         accept_s;

`ifdef MATRIX_MULT_SAT_EN
   localparam logic signed [ACC_W:0] MAX_EXT =
      {{(ACC_W+1-DATA_WIDTH){1'b0}}, 1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W:0] MIN_EXT =
      {{(ACC_W+1-DATA_WIDTH){1'b1}}, 1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif

   // Full-precision signed product of two DATA_WIDTH elements.
   function automatic logic signed [2*DATA_WIDTH-1:0] smul(
      input logic [DATA_WIDTH-1:0] x,
      input logic [DATA_WIDTH-1:0] y
   );
      logic signed [2*DATA_WIDTH-1:0] xe;
      logic signed [2*DATA_WIDTH-1:0] ye;
      xe = {{DATA_WIDTH{x[DATA_WIDTH-1]}}, x};
      ye = {{DATA_WIDTH{y[DATA_WIDTH-1]}}, y};
      return xe * ye;
   endfunction

   // Round, rescale by FORMAT and narrow one accumulator to an output element.
   function automatic logic [DATA_WIDTH-1:0] conv_elem(
      input logic signed [ACC_W-1:0] acc
   );
`ifdef MATRIX_MULT_SAT_EN
      logic signed [ACC_W:0] r;
      r = ($signed({acc[ACC_W-1], acc}) + RND) >>> FORMAT;
      if (r > MAX_EXT) begin
         conv_elem = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else if (r < MIN_EXT) begin
         conv_elem = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else begin
         conv_elem = r[DATA_WIDTH-1:0];
      end
`else
      conv_elem = DATA_WIDTH'(($signed({acc[ACC_W-1], acc}) + RND) >>> FORMAT);
`endif
   endfunction

   assign accept_s = (state_q == S_IDLE) && in_vld;
   assign in_rdy   = rdy_q & ~rst;
   assign out_vld  = vld_q;
   assign C        = c_q;

   // Next-state logic: IDLE -> ACC on accept, ACC for K cycles, OUT until taken.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      case (state_q)
         S_IDLE: begin
            if (in_vld) begin
               state_d = S_ACC;
               k_d     = {KW{1'b0}};
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ACC: begin
            if (k_q == K_LAST) begin
               state_d = S_OUT;
               k_d     = {KW{1'b0}};
            end else begin
               k_d     = k_q + KW'(1);
            end
         end
         S_OUT: begin
            if (out_rdy) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_OUT;
            end
         end
         default: begin
            state_d = S_IDLE;
            k_d     = {KW{1'b0}};
         end
      endcase
   end

   // MAC array: this cycle's partial sums and the converted result they imply.
   always_comb begin
      c_d = '0;
      for (int i = 0; i < M; i++) begin
         for (int j = 0; j < N; j++) begin
            prod_s[i][j] = smul(a_q[i][k_q], b_q[k_q][j]);
            sum_d[i][j]  = acc_q[i][j] + $signed({{(ACC_W-2*DATA_WIDTH){prod_s[i][j][2*DATA_WIDTH-1]}},
                                                   prod_s[i][j]});
            c_d[i][j]    = conv_elem(sum_d[i][j]);
         end
      end
   end

   // Control registers; handshake flags are registered from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         k_q     <= {KW{1'b0}};
         rdy_q   <= 1'b1;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         rdy_q   <= (state_d == S_IDLE);
         vld_q   <= (state_d == S_OUT);
      end
   end

   // Datapath: latch operands on accept, accumulate in ACC, capture C on the last index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q <= '0;
         b_q <= '0;
         c_q <= '0;
         for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
               acc_q[i][j] <= '0;
            end
         end
      end else if (accept_s) begin
         a_q <= A;
         b_q <= B;
         for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
               acc_q[i][j] <= '0;
            end
         end
      end else if (state_q == S_ACC) begin
         for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
               acc_q[i][j] <= sum_d[i][j];
            end
         end
         if (k_q == K_LAST) begin
            c_q <= c_d;
         end
      end
   end

endmodule

// File: tb/tb_matrix_mult_seq.sv
// tb_matrix_mult_seq: directed vectors with hand-computed expectations for
// matrix_mult_seq (4x4x4 instance plus a K=1, M=2, N=3 instance).
module tb_matrix_mult_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic in_vld, in_rdy, out_vld, out_rdy;
   logic signed [3:0][3:0][15:0] a_s, b_s, c_s;

   logic in_vld1, in_rdy1, out_vld1, out_rdy1;
   logic signed [1:0][0:0][15:0] a1_s;
   logic signed [0:0][2:0][15:0] b1_s;
   logic signed [1:0][2:0][15:0] c1_s;

   int total_cnt = 0;
   int bad_cnt   = 0;

   matrix_mult_seq #(.DATA_WIDTH(16), .FORMAT(8), .M(4), .K(4), .N(4)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (in_vld),
      .in_rdy  (in_rdy),
      .A       (a_s),
      .B       (b_s),
      .C       (c_s),
      .out_vld (out_vld),
      .out_rdy (out_rdy)
   );

   matrix_mult_seq #(.DATA_WIDTH(16), .FORMAT(8), .M(2), .K(1), .N(3)) u_dut_k1 (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (in_vld1),
      .in_rdy  (in_rdy1),
      .A       (a1_s),
      .B       (b1_s),
      .C       (c1_s),
      .out_vld (out_vld1),
      .out_rdy (out_rdy1)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Accept edge on the 4x4x4 instance; returns #1 after that edge.
   task automatic accept();
      check("rdy_pre", 16'(in_rdy), 16'd1);
      in_vld = 1'b1;
      @(posedge clk);
      #1;
      in_vld = 1'b0;
   endtask

   // Count edges from the accept edge until out_vld, bounded.
   task automatic wait_out(output int lat);
      lat = 0;
      while (out_vld !== 1'b1 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic load_identity(input logic [15:0] diag);
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            a_s[i][j] = (i == j) ? diag : 16'd0;
            b_s[i][j] = 16'(16*i + j - 20);
         end
      end
   endtask

   task automatic run_round(input logic [15:0] bval, input logic [15:0] exp);
      int lat;
      a_s = '0;
      b_s = '0;
      a_s[0][0] = 16'd1;
      b_s[0][0] = bval;
      accept();
      wait_out(lat);
      check("rnd_lat", 16'(lat), 16'd4);
      check("rnd_c00", c_s[0][0], exp);
      check("rnd_c11", c_s[1][1], 16'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic run_all(input logic [15:0] av, input logic [15:0] bv,
                          input logic [15:0] exp, input string tag);
      int lat;
      a_s = {16{av}};
      b_s = {16{bv}};
      accept();
      wait_out(lat);
      check("ovf_lat", 16'(lat), 16'd4);
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            check(tag, c_s[i][j], exp);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      rst = 1'b1;
      in_vld = 1'b0;
      out_rdy = 1'b1;
      in_vld1 = 1'b0;
      out_rdy1 = 1'b1;
      a_s = '0;
      b_s = '0;
      a1_s = '0;
      b1_s = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_rdy", 16'(in_rdy), 16'd0);
      check("rst_vld", 16'(out_vld), 16'd0);
      check("rst_c", c_s[2][1], 16'd0);
      rst = 1'b0;
      #1;
      check("rel_rdy", 16'(in_rdy), 16'd1);
      @(posedge clk);
      #1;

      // Identity: A = 256*I reproduces B, out_vld 4 cycles after accept
      load_identity(16'd256);
      accept();
      wait_out(lat);
      check("id_lat", 16'(lat), 16'd4);
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            check("ident", c_s[i][j], 16'(16*i + j - 20));
         end
      end
      @(posedge clk);
      #1;
      check("id_vld_1cyc", 16'(out_vld), 16'd0);
      check("id_rdy_back", 16'(in_rdy), 16'd1);

      // Rounding half up
      run_round(16'd128,  16'd1);
      run_round(16'hFF80, 16'd0);
      run_round(16'hFF7F, 16'hFFFF);

      // Overflow
`ifdef MATRIX_MULT_SAT_EN
      run_all(16'h7FFF, 16'h7FFF, 16'h7FFF, "ovf_pos");
      run_all(16'h8000, 16'h7FFF, 16'h8000, "ovf_neg");
`else
      run_all(16'h7FFF, 16'h7FFF, 16'hFC00, "ovf_pos");
      run_all(16'h8000, 16'h7FFF, 16'h0200, "ovf_neg");
`endif

      // Backpressure: hold for 10 cycles with a pending request
      out_rdy = 1'b0;
      load_identity(16'd256);
      accept();
      wait_out(lat);
      check("bp_lat", 16'(lat), 16'd4);
      load_identity(16'd512);
      in_vld = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(posedge clk);
         #1;
         check("bp_vld", 16'(out_vld), 16'd1);
         check("bp_rdy", 16'(in_rdy), 16'd0);
         check("bp_c00", c_s[0][0], 16'hFFEC);
         check("bp_c33", c_s[3][3], 16'd31);
      end
      out_rdy = 1'b1;
      @(posedge clk);
      #1;
      check("bp_rel_vld", 16'(out_vld), 16'd0);
      check("bp_rel_rdy", 16'(in_rdy), 16'd1);
      @(posedge clk);
      #1;
      in_vld = 1'b0;
      check("bp_taken", 16'(in_rdy), 16'd0);
      wait_out(lat);
      check("bp2_lat", 16'(lat), 16'd4);
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            check("bp2_c", c_s[i][j], 16'(2*(16*i + j - 20)));
         end
      end
      @(posedge clk);
      #1;

      // Reset in the middle of accumulation (k=2)
      load_identity(16'd256);
      accept();
      repeat (2) @(posedge clk);
      #1;
      #2;
      rst = 1'b1;
      #1;
      check("mrst_vld", 16'(out_vld), 16'd0);
      check("mrst_rdy", 16'(in_rdy), 16'd0);
      check("mrst_c00", c_s[0][0], 16'd0);
      check("mrst_c33", c_s[3][3], 16'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("mrst_rel_rdy", 16'(in_rdy), 16'd1);
      repeat (6) @(posedge clk);
      #1;
      check("mrst_discard", 16'(out_vld), 16'd0);
      accept();
      wait_out(lat);
      check("mrst_lat", 16'(lat), 16'd4);
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            check("mrst_id", c_s[i][j], 16'(16*i + j - 20));
         end
      end
      @(posedge clk);
      #1;

      // K=1, M=2, N=3
      a1_s[0][0] = 16'd256;
      a1_s[1][0] = 16'd512;
      for (int j = 0; j < 3; j++) begin
         b1_s[0][j] = 16'(j + 1);
      end
      check("k1_rdy", 16'(in_rdy1), 16'd1);
      in_vld1 = 1'b1;
      @(posedge clk);
      #1;
      in_vld1 = 1'b0;
      lat = 0;
      while (out_vld1 !== 1'b1 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("k1_lat", 16'(lat), 16'd1);
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 3; j++) begin
            check("k1_c", c1_s[i][j], 16'((i + 1)*(j + 1)));
         end
      end
      @(posedge clk);
      #1;
      check("k1_vld_1cyc", 16'(out_vld1), 16'd0);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule

// File: doc/matrix_mult_seq.md
# matrix_mult_seq

Sequential fixed-point matrix multiplier computing C = A·B for an M×K by K×N signed operand pair. It accepts whole matrices on a valid/ready handshake and accumulates one inner-dimension index per cycle on an M×N MAC array. The result is rounded, rescaled by FORMAT fractional bits and saturated, then held on the output until accepted. It sits in the video processing path wherever colour-space or transform matrices are applied, replacing fully combinational single-cycle products.

## Interface
- DATA_WIDTH, 16, signed element width of A, B and C.
- FORMAT, 8, fractional bits of every operand and of the result; legal range 0..2*DATA_WIDTH-1, with elaboration error outside it.
- M, 4, rows of A and of C (≥1).
- K, 4, columns of A and rows of B (≥1).
- N, 4, columns of B and of C (≥1).

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_vld  in  1  A and B are valid.
- in_rdy  out  1  block can accept an operand pair.
- A  in  signed [DATA_WIDTH-1:0] [M][K]  left operand.
- B  in  signed [DATA_WIDTH-1:0] [K][N]  right operand.
- C  out  signed [DATA_WIDTH-1:0] [M][N]  result, registered.
- out_vld  out  1  C is valid.
- out_rdy  in  1  downstream accepts C.

## Operation
- FSM states:
  - IDLE: in_rdy=1. On in_vld&in_rdy, A and B are latched into internal registers, all accumulators are cleared, k=0, and the FSM goes to ACC.
  - ACC: every cycle, acc[i][j] += Areg[i][k]*Breg[k][j] for all i,j, and k increments. On the cycle where k=K-1, the final sum is formed and C is registered in the same edge; the FSM goes to OUT.
  - OUT: out_vld=1, and C is stable. On out_rdy, the FSM goes to IDLE.
- in_rdy is asserted only in IDLE. There is no bypass: the next accept is at the earliest one cycle after the output handshake.
- Width rules:
  - Each product is 2*DATA_WIDTH bits, signed.
  - The accumulator is ACC_W = 2*DATA_WIDTH + $clog2(K)+1 bits, signed, and never overflows.
- Output conversion, per element:
  - r = (acc + (FORMAT>0 ? 1<<(FORMAT-1) : 0)) >>> FORMAT. This is round-half-up and is performed at ACC_W+1 bits.
  - r is then saturated or wrapped to DATA_WIDTH bits (see Configuration).
- Input changes while not in IDLE are ignored.
- in_vld may be asserted without in_rdy; the request waits and nothing is latched.
- Reset, asynchronous and mid-operation included, forces:
  - FSM to IDLE, k=0;
  - in_rdy=1 after reset release (0 while rst is high);
  - out_vld=0 and all C elements=0; accumulators=0.
  - Any in-flight result is discarded.

## Timing
- Accept edge at cycle t; accumulation edges at t+1..t+K.
- out_vld rises after edge t+K, i.e. K cycles after the accept edge, and C is valid in the same cycle.
- With out_rdy held at 1:
  - out_vld is high for exactly one cycle;
  - in_rdy returns the cycle after;
  - throughput is one matrix per K+2 cycles.
- Under backpressure, out_vld and C hold indefinitely and in_rdy stays 0.
- K=1: a single ACC cycle; out_vld rises one cycle after the accept edge.

## Configuration
- MATRIX_MULT_SAT_EN defined:
  - r > 2^(DATA_WIDTH-1)-1 clamps to the maximum positive value;
  - r < -2^(DATA_WIDTH-1) clamps to the minimum negative value.
- MATRIX_MULT_SAT_EN undefined: C takes r[DATA_WIDTH-1:0], two's-complement wrap, with no comparator logic.

## Test plan
All scenarios use DATA_WIDTH=16, FORMAT=8, M=K=N=4 unless stated.

- Identity: A=256·I, B[i][j]=16·i+j-20 → C equals B exactly, and out_vld rises 4 cycles after the accept edge.
- Rounding:
  - A[0][0]=1 and B[0][0]=128, all others 0 → C[0][0]=1.
  - B[0][0]=-128 → C[0][0]=0.
  - B[0][0]=-129 → C[0][0]=-1.
- Overflow, all A=B=0x7FFF:
  - with MATRIX_MULT_SAT_EN, every C element=0x7FFF;
  - without it, every C element=0xFC00.
  - With A=0x8000 and B=0x7FFF, the saturated result is 0x8000.
- Backpressure: out_rdy=0 for 10 cycles after out_vld → C and out_vld stable, in_rdy=0, and a held in_vld is not accepted. Raising out_rdy → in_rdy=1 on the next cycle and the held request is accepted.
- Reset mid-ACC: assert rst at k=2 → out_vld=0, C=0 and in_rdy=0 immediately (asynchronously). After release, in_rdy=1 and a fresh identity transaction produces correct results.
- K=1, M=2, N=3: A=[[256],[512]], B=[[1,2,3]] → C=[[1,2,3],[2,4,6]], and out_vld rises one cycle after the accept edge.
